fp_vec_driver: RTL and testbench
================================

# fp_vec_driver

Synthesizable vector driver and checker between a test-vector source and `fp_unit`. It accepts packed 156-bit FPU test vectors over a valid/ready stream and buffers them in a small FIFO. It issues each vector to `fp_unit` one at a time, then compares the returned result and flags against the expected values. It keeps a pass count, latches the first failing vector, and reports sticky done/fail status so regressions can run on-chip or in simulation without a behavioural file reader.

## Interface

Parameters:
- DEPTH, 4, vector FIFO entries (power of two, ≥2)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- vec_valid  in  1  source has a vector
- vec_data  in  156  packed vector:
  - data1 [155:124], data2 [123:92], data3 [91:60]
  - expected result [59:28], expected flags [24:20]
  - rm [18:16], fcvt_op [13:12], opcode one-hot [9:0]
- vec_last  in  1  marks final vector of stream; qualified by vec_valid
- vec_ready  out  1  FIFO can accept
- exe_enable  out  1  one-cycle issue strobe to fp_unit
- exe_data1, exe_data2, exe_data3  out  32 each  operands
- exe_fmt  out  2  always 0 (single precision)
- exe_rm  out  3  rounding mode
- exe_fcvt_op  out  2  conversion sub-op
- exe_opcode  out  10  opcode bits. Bit map: 0 fmadd, 1 fadd, 2 fsub, 3 fmul, 4 fdiv, 5 fsqrt, 6 fcmp, 8 fcvt_i2f, 9 fcvt_f2i. Bit 7 is driven 0.
- exe_result  in  32  fp_unit result
- exe_flags  in  5  fp_unit flags
- exe_ready  in  1  fp_unit result valid
- done  out  1  sticky: last vector checked, no failure
- fail  out  1  sticky: mismatch detected
- pass_count  out  32  vectors passed, saturating
- fail_vec  out  156  captured failing vector
- fail_result  out  32  captured calculated result
- fail_flags  out  5  captured calculated flags

## Operation

- FIFO:
  - Stores {vec_last, vec_data}.
  - Push when vec_valid & vec_ready.
  - vec_ready = !full & state ∉ {DONE, FAIL}.
- Issue register: holds the in-flight vector. exe_* fields are driven from it and stay stable from issue until the result is checked.
- FSM states: IDLE, WAIT, DONE, FAIL.
- IDLE:
  - If FIFO is non-empty: pop into the issue register, set exe_enable=1 for one cycle, go to WAIT.
  - If FIFO is empty: stay in IDLE.
- WAIT:
  - exe_ready=0: hold.
  - exe_ready=1: compare.
    - Pass and entry was last: go to DONE.
    - Pass otherwise: go to IDLE.
    - Mismatch: go to FAIL.
- Compare rule:
  - NaN-masked case: opcode[9]=0 and opcode[6]=0 and exe_result=0x7FC00000. The result matches iff exe_result[30:22] == expected[30:22].
  - Otherwise the result must match on all 32 bits.
  - Flags must always match on all 5 bits.
- On pass: pass_count increments; it saturates at 0xFFFFFFFF.
- On mismatch:
  - fail_vec, fail_result and fail_flags capture the failing vector and calculated values.
  - fail is set.
- DONE/FAIL:
  - Terminal until reset.
  - No further issue; FIFO contents are ignored.
- exe_ready outside WAIT is ignored.

## Timing

- Reset values: every output is 0 except vec_ready, which is 1 in the cycle after reset is released. FIFO is empty, FSM is in IDLE.
- Reset asserted mid-operation: at the next edge, FSM returns to IDLE, FIFO is flushed, and counters and captures clear. An exe_ready from the aborted op arriving later is ignored because the FSM is not in WAIT.
- Issue latency:
  - A vector pushed at edge N with FIFO empty and FSM in IDLE is popped at edge N+1.
  - exe_enable is high from N+1 to N+2; exe_* fields are valid from N+1.
- Check: exe_ready sampled high at edge M updates pass_count, fail, done and the captures at M. The next issue strobe is at M+1 at the earliest.
- Simultaneous push and pop in the same edge is allowed; the occupancy count is unchanged.
- Capacity: the issue register plus DEPTH FIFO entries, so DEPTH+1 vectors can be outstanding before vec_ready drops.
- Only one operation is ever in flight at fp_unit.

## Test plan

- Reset: hold reset 3 cycles, release → all outputs 0; vec_ready=1 after release; exe_enable stays 0 with no input.
- Single pass:
  - Stimulus: fadd vector, data1=0x3F800000, data2=0x40000000, expected 0x40400000, flags 0, vec_last=1. Model returns a matching result 3 cycles after exe_enable.
  - Response: exe_enable pulses exactly once; pass_count=1; done=1; fail=0; vec_ready=0 afterwards.
- NaN masking:
  - fadd, expected 0x7FC00001, calc 0x7FC00000, flags match → pass.
  - Same values with opcode[9]=1 (fcvt_f2i) → fail=1, fail_result=0x7FC00000.
- Flag mismatch:
  - Stimulus: fmul, result matches, expected flags 0x01, calc 0x00.
  - Response: fail=1; fail_vec equals the input vector; fail_flags=0x00; later queued vectors are never issued; vec_ready=0.
- Backpressure (DEPTH=4):
  - Stimulus: model stalls exe_ready for 20 cycles; source offers 8 vectors back-to-back.
  - Response: exactly 5 accepted before vec_ready falls; after the stall releases, all 8 are issued in order and pass_count=8.
- Reset mid-WAIT: assert reset while in WAIT, then drive exe_ready the cycle after release → ignored; pass_count=0, fail=0, FIFO empty.

Source files
------------

// File: rtl/fp_vec_driver_if.sv
// Vector stream, fp_unit issue/return and status signals of fp_vec_driver.
// master is the driver itself; slave is the surrounding source/fp_unit/observer.
interface fp_vec_driver_if;
   logic         vec_valid;
   logic [155:0] vec_data;
   logic         vec_last;
   logic         vec_ready;
   logic         exe_enable;
   logic [31:0]  exe_data1;
   logic [31:0]  exe_data2;
   logic [31:0]  exe_data3;
   logic [1:0]   exe_fmt;
   logic [2:0]   exe_rm;
   logic [1:0]   exe_fcvt_op;
   logic [9:0]   exe_opcode;
   logic [31:0]  exe_result;
   logic [4:0]   exe_flags;
   logic         exe_ready;
   logic         done;
   logic         fail;
   logic [31:0]  pass_count;
   logic [155:0] fail_vec;
   logic [31:0]  fail_result;
   logic [4:0]   fail_flags;

   modport master (
      input  vec_valid, vec_data, vec_last, exe_result, exe_flags, exe_ready,
      output vec_ready, exe_enable, exe_data1, exe_data2, exe_data3, exe_fmt,
             exe_rm, exe_fcvt_op, exe_opcode, done, fail, pass_count,
             fail_vec, fail_result, fail_flags
   );

   modport slave (
      output vec_valid, vec_data, vec_last, exe_result, exe_flags, exe_ready,
      input  vec_ready, exe_enable, exe_data1, exe_data2, exe_data3, exe_fmt,
             exe_rm, exe_fcvt_op, exe_opcode, done, fail, pass_count,
             fail_vec, fail_result, fail_flags
   );
endinterface

// File: rtl/fp_vec_driver.sv
// Buffers packed FPU test vectors, issues them one at a time to fp_unit and
// checks each returned result/flags pair, keeping sticky done/fail status.
module fp_vec_driver #(
   parameter int DEPTH = 4
) (
   input logic             clock,
   input logic             reset,
   fp_vec_driver_if.master bus
);
   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

   typedef enum logic [1:0] {IDLE, WAIT, DONE, FAIL} state_e;

   state_e       state_q, state_d;
   logic [156:0] mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]  count;
   logic [156:0] head;
   logic         push, pop, chk_pass, chk_fail;
   logic [155:0] iss_q, iss_d;
   logic         iss_last_q, iss_last_d;
   logic         exe_en_q, exe_en_d;
   logic [31:0]  pass_q, pass_d;
   logic [155:0] fvec_q, fvec_d;
   logic [31:0]  fres_q, fres_d;
   logic [4:0]   fflg_q, fflg_d;

   // A canonical quiet NaN from a non-compare, non-f2i op only has to agree
   // on exponent and quiet bit, since NaN payloads differ between models.
   function automatic logic result_ok(input logic [31:0] expv, input logic [4:0] exp_flg,
                                      input logic op_f2i, input logic op_cmp,
                                      input logic [31:0] res, input logic [4:0] flg);
      logic nan_mask;
      nan_mask = !op_f2i && !op_cmp && (res == 32'h7FC0_0000);
      if (flg != exp_flg) return 1'b0;
      if (nan_mask)       return res[30:22] == expv[30:22];
      return res == expv;
   endfunction

   assign count         = wr_ptr_q - rd_ptr_q;
   assign head          = mem_q[rd_ptr_q[AW-1:0]];
   assign bus.vec_ready = (count != FULL_CNT) && (state_q != DONE) && (state_q != FAIL);
   assign push          = bus.vec_valid && bus.vec_ready;

   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      chk_pass = 1'b0;
      chk_fail = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (count != '0) begin
               pop     = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus.exe_ready) begin
               if (result_ok(iss_q[59:28], iss_q[24:20], iss_q[9], iss_q[6],
                             bus.exe_result, bus.exe_flags)) begin
                  chk_pass = 1'b1;
                  state_d  = iss_last_q ? DONE : IDLE;
               end else begin
                  chk_fail = 1'b1;
                  state_d  = FAIL;
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      iss_d      = pop  ? head[155:0] : iss_q;
      iss_last_d = pop  ? head[156]   : iss_last_q;
      exe_en_d   = pop;
      pass_d     = (chk_pass && (pass_q != 32'hFFFF_FFFF)) ? pass_q + 32'd1 : pass_q;
      fvec_d     = chk_fail ? iss_q          : fvec_q;
      fres_d     = chk_fail ? bus.exe_result : fres_q;
      fflg_d     = chk_fail ? bus.exe_flags  : fflg_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         iss_q      <= '0;
         iss_last_q <= 1'b0;
         exe_en_q   <= 1'b0;
         pass_q     <= '0;
         fvec_q     <= '0;
         fres_q     <= '0;
         fflg_q     <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         iss_q      <= iss_d;
         iss_last_q <= iss_last_d;
         exe_en_q   <= exe_en_d;
         pass_q     <= pass_d;
         fvec_q     <= fvec_d;
         fres_q     <= fres_d;
         fflg_q     <= fflg_d;
      end
   end

   // FIFO storage needs no reset: the pointers define which entries are live.
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= {bus.vec_last, bus.vec_data};
   end

   assign bus.exe_enable  = exe_en_q;
   assign bus.exe_data1   = iss_q[155:124];
   assign bus.exe_data2   = iss_q[123:92];
   assign bus.exe_data3   = iss_q[91:60];
   assign bus.exe_fmt     = 2'b00;
   assign bus.exe_rm      = iss_q[18:16];
   assign bus.exe_fcvt_op = iss_q[13:12];
   assign bus.exe_opcode  = {iss_q[9:8], 1'b0, iss_q[6:0]};
   assign bus.done        = (state_q == DONE);
   assign bus.fail        = (state_q == FAIL);
   assign bus.pass_count  = pass_q;
   assign bus.fail_vec    = fvec_q;
   assign bus.fail_result = fres_q;
   assign bus.fail_flags  = fflg_q;
endmodule

// File: tb/tb_fp_vec_driver.sv
// Bench for fp_vec_driver: source driver, fp_unit responder and a spec-level
// pass/fail predictor for randomized vector streams.
module tb_fp_vec_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_vec_driver_if bus();
  fp_vec_driver #(.DEPTH(4)) dut (.clock(clk), .reset(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  // responder controls (written by the main process only)
  int          lat = 2;
  bit          stall = 1'b0;
  bit          force_rdy = 1'b0;
  logic [31:0] force_res = '0;
  logic [4:0]  force_flags = '0;

  // responder observations (written by the responder only)
  int           enable_pulses = 0;
  logic [112:0] issued_q[$];

  // accepted vectors and their planned responses (main process only)
  logic [155:0] acc_vec_q[$];
  logic [36:0]  acc_rsp_q[$];
  int           base_pulses = 0;
  int           base_issued = 0;

  function automatic logic [155:0] mkvec(input logic [31:0] d1, input logic [31:0] d2,
                                         input logic [31:0] d3, input logic [31:0] expv,
                                         input logic [4:0] ef, input logic [2:0] rm,
                                         input logic [1:0] fc, input logic [9:0] op);
    logic [155:0] v;
    v = '0;
    v[155:124] = d1; v[123:92] = d2; v[91:60] = d3; v[59:28] = expv;
    v[24:20] = ef; v[18:16] = rm; v[13:12] = fc; v[9:0] = op;
    return v;
  endfunction

  // what fp_unit should see for a given vector: operands, rm, fcvt, opcode without bit 7, fmt 0
  function automatic logic [112:0] fields_of(input logic [155:0] v);
    return {v[155:124], v[123:92], v[91:60], v[18:16], v[13:12], v[9:8], 1'b0, v[6:0], 2'b00};
  endfunction

  // Reference verdict: flags exact; a canonical quiet NaN (0x7FC00000, whose bits
  // 30:22 are all ones) from an op other than fcmp/fcvt_f2i is accepted whenever the
  // expected value also has bits 30:22 all ones; otherwise the value must be identical.
  function automatic bit spec_pass(input logic [155:0] v, input logic [31:0] res, input logic [4:0] flg);
    logic [31:0] expv;
    expv = v[59:28];
    if (flg != v[24:20]) return 1'b0;
    if (res == 32'h7FC0_0000 && !v[9] && !v[6]) return expv[30:22] == 9'h1FF;
    return res == expv;
  endfunction

  function automatic int pulses();
    return enable_pulses - base_pulses;
  endfunction

  // fp_unit model: returns the planned response lat cycles after each issue
  initial begin : fp_unit_model
    bit pending;
    int cnt;
    pending = 1'b0; cnt = 0;
    bus.exe_ready = 1'b0; bus.exe_result = '0; bus.exe_flags = '0;
    forever begin
      @(posedge clk); #2;
      bus.exe_ready = 1'b0;
      if (rst) begin
        pending = 1'b0;
      end else if (force_rdy) begin
        bus.exe_ready = 1'b1; bus.exe_result = force_res; bus.exe_flags = force_flags;
      end else begin
        if (bus.exe_enable) begin
          enable_pulses++;
          issued_q.push_back({bus.exe_data1, bus.exe_data2, bus.exe_data3, bus.exe_rm,
                              bus.exe_fcvt_op, bus.exe_opcode, bus.exe_fmt});
          pending = 1'b1; cnt = lat;
        end
        if (pending && !stall) begin
          if (cnt == 0) begin
            if (enable_pulses - base_pulses - 1 < acc_rsp_q.size())
              {bus.exe_result, bus.exe_flags} = acc_rsp_q[enable_pulses - base_pulses - 1];
            bus.exe_ready = 1'b1; pending = 1'b0;
          end else cnt--;
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    bus.vec_valid = 1'b0; bus.vec_last = 1'b0; bus.vec_data = '0;
    stall = 1'b0; force_rdy = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    acc_vec_q.delete(); acc_rsp_q.delete();
    base_pulses = enable_pulses; base_issued = issued_q.size();
  endtask

  task automatic send(input logic [155:0] v, input bit last, input logic [31:0] res,
                      input logic [4:0] flg, input int bound, output bit acc);
    bit r;
    bus.vec_valid = 1'b1; bus.vec_data = v; bus.vec_last = last; acc = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk); r = bus.vec_ready;
      @(posedge clk); #1;
      if (r) begin
        acc = 1'b1; acc_vec_q.push_back(v); acc_rsp_q.push_back({res, flg});
        break;
      end
    end
  endtask

  task automatic src_idle();
    bus.vec_valid = 1'b0; bus.vec_last = 1'b0;
  endtask

  task automatic wait_term(input int bound, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(posedge clk); #1;
      if (bus.done || bus.fail) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.vec_ready !== 1'b1) begin errors++; $display("FAIL reset_vec_ready: got %b want 1", bus.vec_ready); end
    checks++; if ({bus.exe_enable, bus.done, bus.fail} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b want 000", {bus.exe_enable, bus.done, bus.fail}); end
    checks++; if (bus.pass_count !== 32'd0) begin errors++; $display("FAIL reset_pass_count: got %h want 0", bus.pass_count); end
    checks++; if ({bus.fail_vec, bus.fail_result, bus.fail_flags} !== '0) begin errors++; $display("FAIL reset_captures: got %h want 0", {bus.fail_vec, bus.fail_result, bus.fail_flags}); end
    checks++; if ({bus.exe_data1, bus.exe_data2, bus.exe_data3, bus.exe_fmt, bus.exe_rm, bus.exe_fcvt_op, bus.exe_opcode} !== '0) begin errors++; $display("FAIL reset_exe_fields: got %h want 0", {bus.exe_data1, bus.exe_opcode}); end
    repeat (6) @(posedge clk); #1;
    checks++; if (pulses() != 0) begin errors++; $display("FAIL reset_no_issue: got %0d pulses want 0", pulses()); end
  endtask

  task automatic test_single_pass();
    logic [155:0] v;
    bit acc, ok;
    do_reset(); lat = 3;
    v = mkvec(32'h3F80_0000, 32'h4000_0000, 32'h0, 32'h4040_0000, 5'h00, 3'd0, 2'd0, 10'b00_0000_0010);
    send(v, 1'b1, 32'h4040_0000, 5'h00, 20, acc); src_idle();
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL single_accept: got %b want 1", acc); end
    checks++; if (bus.exe_enable !== 1'b0) begin errors++; $display("FAIL single_enable_early: got %b want 0", bus.exe_enable); end
    @(posedge clk); #1;
    checks++; if (bus.exe_enable !== 1'b1) begin errors++; $display("FAIL single_enable_issue: got %b want 1", bus.exe_enable); end
    checks++; if ({bus.exe_data1, bus.exe_data2, bus.exe_data3, bus.exe_rm, bus.exe_fcvt_op, bus.exe_opcode, bus.exe_fmt} !== fields_of(v)) begin errors++; $display("FAIL single_fields: got %h want %h", {bus.exe_data1, bus.exe_data2, bus.exe_data3, bus.exe_rm, bus.exe_fcvt_op, bus.exe_opcode, bus.exe_fmt}, fields_of(v)); end
    @(posedge clk); #1;
    checks++; if (bus.exe_enable !== 1'b0) begin errors++; $display("FAIL single_enable_pulse: got %b want 0", bus.exe_enable); end
    checks++; if (bus.exe_data1 !== 32'h3F80_0000) begin errors++; $display("FAIL single_data_stable: got %h want 3f800000", bus.exe_data1); end
    wait_term(50, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_terminate: got %b want 1", ok); end
    repeat (5) @(posedge clk); #1;
    checks++; if (pulses() != 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", pulses()); end
    checks++; if (bus.pass_count !== 32'd1) begin errors++; $display("FAIL single_pass_count: got %0d want 1", bus.pass_count); end
    checks++; if ({bus.done, bus.fail} !== 2'b10) begin errors++; $display("FAIL single_done_fail: got %b want 10", {bus.done, bus.fail}); end
    checks++; if (bus.vec_ready !== 1'b0) begin errors++; $display("FAIL single_ready_after: got %b want 0", bus.vec_ready); end
  endtask

  task automatic test_nan_mask();
    logic [155:0] v;
    bit acc, ok;
    do_reset(); lat = 1;
    v = mkvec(32'h7FC0_0000, 32'h3F80_0000, 32'h0, 32'h7FC0_0001, 5'h00, 3'd1, 2'd0, 10'b00_0000_0010);
    send(v, 1'b1, 32'h7FC0_0000, 5'h00, 20, acc); src_idle();
    wait_term(50, ok);
    checks++; if ({ok, bus.done, bus.fail} !== 3'b110) begin errors++; $display("FAIL nan_fadd_status: got %b want 110", {ok, bus.done, bus.fail}); end
    checks++; if (bus.pass_count !== 32'd1) begin errors++; $display("FAIL nan_fadd_pass_count: got %0d want 1", bus.pass_count); end
    do_reset();
    v[9:0] = 10'b10_0000_0000;
    send(v, 1'b1, 32'h7FC0_0000, 5'h00, 20, acc); src_idle();
    wait_term(50, ok);
    checks++; if ({ok, bus.done, bus.fail} !== 3'b101) begin errors++; $display("FAIL nan_f2i_status: got %b want 101", {ok, bus.done, bus.fail}); end
    checks++; if (bus.fail_result !== 32'h7FC0_0000) begin errors++; $display("FAIL nan_f2i_fail_result: got %h want 7fc00000", bus.fail_result); end
    checks++; if (bus.pass_count !== 32'd0) begin errors++; $display("FAIL nan_f2i_pass_count: got %0d want 0", bus.pass_count); end
  endtask

  task automatic test_flag_mismatch();
    logic [155:0] v0, v1, v2;
    logic [31:0] x;
    bit acc, ok;
    do_reset(); lat = 2; stall = 1'b1;
    x  = $urandom;
    v0 = mkvec($urandom, $urandom, 32'h0, x, 5'h01, 3'd2, 2'd0, 10'b00_0000_1000);
    v1 = mkvec($urandom, $urandom, 32'h0, 32'h4040_0000, 5'h00, 3'd0, 2'd0, 10'b00_0000_0010);
    v2 = mkvec($urandom, $urandom, 32'h0, 32'h4080_0000, 5'h00, 3'd0, 2'd0, 10'b00_0000_0010);
    send(v0, 1'b0, x, 5'h00, 20, acc);
    send(v1, 1'b0, 32'h4040_0000, 5'h00, 20, acc);
    send(v2, 1'b1, 32'h4080_0000, 5'h00, 20, acc);
    src_idle();
    stall = 1'b0;
    wait_term(100, ok);
    repeat (10) @(posedge clk); #1;
    checks++; if ({ok, bus.done, bus.fail} !== 3'b101) begin errors++; $display("FAIL flag_status: got %b want 101", {ok, bus.done, bus.fail}); end
    checks++; if (bus.fail_vec !== v0) begin errors++; $display("FAIL flag_fail_vec: got %h want %h", bus.fail_vec, v0); end
    checks++; if (bus.fail_flags !== 5'h00) begin errors++; $display("FAIL flag_fail_flags: got %h want 00", bus.fail_flags); end
    checks++; if (bus.fail_result !== x) begin errors++; $display("FAIL flag_fail_result: got %h want %h", bus.fail_result, x); end
    checks++; if (pulses() != 1) begin errors++; $display("FAIL flag_no_more_issue: got %0d pulses want 1", pulses()); end
    checks++; if ({bus.vec_ready, bus.pass_count} !== 33'd0) begin errors++; $display("FAIL flag_ready_count: got ready=%b count=%0d want 0/0", bus.vec_ready, bus.pass_count); end
  endtask

  task automatic test_backpressure();
    logic [155:0] vs[8];
    bit ok;
    do_reset(); lat = 1; stall = 1'b1;
    for (int i = 0; i < 8; i++)
      vs[i] = mkvec($urandom, $urandom, $urandom, $urandom, 5'($urandom), 3'($urandom), 2'($urandom), 10'(1 << $urandom_range(0, 5)));
    fork
      begin
        bit a;
        for (int i = 0; i < 8; i++) begin
          send(vs[i], i == 7, vs[i][59:28], vs[i][24:20], 300, a);
          if (!a) break;
        end
        src_idle();
      end
      begin
        repeat (20) @(posedge clk); #3;
        checks++; if (acc_vec_q.size() != 5) begin errors++; $display("FAIL bp_accepted: got %0d want 5", acc_vec_q.size()); end
        checks++; if (bus.vec_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b want 0", bus.vec_ready); end
        checks++; if (pulses() != 1) begin errors++; $display("FAIL bp_single_inflight: got %0d want 1", pulses()); end
        stall = 1'b0;
      end
    join
    wait_term(400, ok);
    repeat (3) @(posedge clk); #1;
    checks++; if ({ok, bus.done, bus.fail} !== 3'b110) begin errors++; $display("FAIL bp_status: got %b want 110", {ok, bus.done, bus.fail}); end
    checks++; if (bus.pass_count !== 32'd8) begin errors++; $display("FAIL bp_pass_count: got %0d want 8", bus.pass_count); end
    checks++; if (pulses() != 8) begin errors++; $display("FAIL bp_pulses: got %0d want 8", pulses()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (base_issued + i >= issued_q.size()) begin errors++; $display("FAIL bp_order_%0d: got none want %h", i, fields_of(vs[i])); end
      else if (issued_q[base_issued + i] !== fields_of(vs[i])) begin errors++; $display("FAIL bp_order_%0d: got %h want %h", i, issued_q[base_issued + i], fields_of(vs[i])); end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [155:0] v;
    bit acc;
    do_reset(); lat = 0; stall = 1'b1;
    v = mkvec(32'h3F80_0000, 32'h3F80_0000, 32'h0, 32'h4000_0000, 5'h00, 3'd0, 2'd0, 10'b00_0000_0010);
    send(v, 1'b1, 32'h4000_0000, 5'h00, 20, acc); src_idle();
    repeat (3) @(posedge clk); #1;
    checks++; if (pulses() != 1) begin errors++; $display("FAIL midwait_issued: got %0d want 1", pulses()); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; force_res = 32'h4000_0000; force_flags = 5'h00; force_rdy = 1'b1;
    @(posedge clk); #1;
    force_rdy = 1'b0; stall = 1'b0;
    repeat (5) @(posedge clk); #1;
    checks++; if ({bus.done, bus.fail, bus.pass_count} !== 34'd0) begin errors++; $display("FAIL midwait_ignored: got done=%b fail=%b count=%0d want 0", bus.done, bus.fail, bus.pass_count); end
    checks++; if (bus.vec_ready !== 1'b1) begin errors++; $display("FAIL midwait_ready: got %b want 1", bus.vec_ready); end
    checks++; if (pulses() != 1) begin errors++; $display("FAIL midwait_fifo_empty: got %0d pulses want 1", pulses()); end
    checks++; if (bus.exe_data1 !== 32'h0) begin errors++; $display("FAIL midwait_issue_cleared: got %h want 0", bus.exe_data1); end
  endtask

  task automatic test_random();
    int opbits[9] = '{0, 1, 2, 3, 4, 5, 6, 8, 9};
    logic [155:0] vs[6];
    logic [31:0]  rs[6];
    logic [4:0]   fs[6];
    int first_fail, exp_pass, exp_issued, kind;
    bit acc, ok;
    for (int round = 0; round < 5; round++) begin
      do_reset(); lat = $urandom_range(0, 4);
      for (int i = 0; i < 6; i++) begin
        logic [9:0] op;
        logic [31:0] e;
        op = '0; op[opbits[$urandom_range(0, 8)]] = 1'b1;
        if ($urandom_range(0, 3) == 0) op[7] = 1'b1;
        e = $urandom;
        kind = $urandom_range(0, 14);
        if ((kind == 10 || kind == 11) && $urandom_range(0, 1) == 1) e[30:22] = 9'h1FF;
        vs[i] = mkvec($urandom, $urandom, $urandom, e, 5'($urandom), 3'($urandom), 2'($urandom), op);
        vs[i][27:25] = 3'($urandom); vs[i][19] = 1'($urandom);
        vs[i][15:14] = 2'($urandom); vs[i][11:10] = 2'($urandom);
        rs[i] = e; fs[i] = vs[i][24:20];
        if (kind == 10 || kind == 11) rs[i] = 32'h7FC0_0000;
        else if (kind == 12) fs[i] = fs[i] ^ 5'(1 << $urandom_range(0, 4));
        else if (kind >= 13) rs[i] = e ^ (32'h1 << $urandom_range(0, 31));
      end
      first_fail = -1;
      for (int i = 0; i < 6; i++)
        if (first_fail < 0 && !spec_pass(vs[i], rs[i], fs[i])) first_fail = i;
      exp_pass   = (first_fail < 0) ? 6 : first_fail;
      exp_issued = (first_fail < 0) ? 6 : first_fail + 1;
      for (int i = 0; i < 6; i++) begin
        send(vs[i], i == 5, rs[i], fs[i], 40, acc);
        if (!acc) break;
      end
      src_idle();
      wait_term(300, ok);
      repeat (3) @(posedge clk); #1;
      checks++; if ({ok, bus.done, bus.fail} !== {1'b1, first_fail < 0, first_fail >= 0}) begin errors++; $display("FAIL rand%0d_status: got %b want %b", round, {ok, bus.done, bus.fail}, {1'b1, first_fail < 0, first_fail >= 0}); end
      checks++; if (bus.pass_count !== 32'(exp_pass)) begin errors++; $display("FAIL rand%0d_pass_count: got %0d want %0d", round, bus.pass_count, exp_pass); end
      checks++; if (pulses() != exp_issued) begin errors++; $display("FAIL rand%0d_issued: got %0d want %0d", round, pulses(), exp_issued); end
      if (first_fail >= 0) begin
        checks++; if ({bus.fail_vec, bus.fail_result, bus.fail_flags} !== {vs[first_fail], rs[first_fail], fs[first_fail]}) begin errors++; $display("FAIL rand%0d_capture: got %h/%h/%h want %h/%h/%h", round, bus.fail_vec, bus.fail_result, bus.fail_flags, vs[first_fail], rs[first_fail], fs[first_fail]); end
      end
      for (int i = 0; i < exp_issued; i++) begin
        checks++;
        if (base_issued + i >= issued_q.size()) begin errors++; $display("FAIL rand%0d_order_%0d: got none want %h", round, i, fields_of(vs[i])); end
        else if (issued_q[base_issued + i] !== fields_of(vs[i])) begin errors++; $display("FAIL rand%0d_order_%0d: got %h want %h", round, i, issued_q[base_issued + i], fields_of(vs[i])); end
      end
    end
  endtask

  initial begin : main
    bus.vec_valid = 1'b0; bus.vec_last = 1'b0; bus.vec_data = '0;
    test_reset();
    test_single_pass();
    test_nan_mask();
    test_flag_mismatch();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
